// File: rtl/recip_pkg.sv
// Shared types and constants for the Newton-Raphson reciprocal unit.
// Seed ROM is only referenced when RECIP_SEED_LUT_EN is defined.
package recip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_D,
    MUL_X,
    NORM,
    DONE
  } state_e;

  // 1.0 in Q1.(w-1)
  function automatic logic [63:0] ONE_Q(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // 2.0 in Q1.(w-1), i.e. 1<<w
  function automatic logic [63:0] TWO_Q(input int w);
    return 64'd1 << w;
  endfunction

  // 1/midpoint of [1+i/16, 1+(i+1)/16), rounded, Q1.23
  localparam logic [23:0] SEED_ROM [16] = '{
    24'h7C1F08, 24'h750750, 24'h6EB3E4, 24'h690690,
    24'h63E706, 24'h5F417D, 24'h5B05B0, 24'h572621,
    24'h539783, 24'h505050, 24'h4D4874, 24'h4A7905,
    24'h47DC12, 24'h456C79, 24'h4325C5, 24'h410410
  };

endpackage

// File: rtl/recip_nr_datapath.sv
// One shared multiplier serving both halves of x <= x*(2 - x*D).
// MUL_D phase yields t = 2 - x*D; MUL_X phase yields saturated x*t.
module recip_nr_datapath
  import recip_pkg::*;
#(
  parameter int MANT_W = 24
) (
  input  logic              sel_x_i,
  input  logic [MANT_W-1:0] x_i,
  input  logic [MANT_W-1:0] d_i,
  input  logic [MANT_W:0]   t_i,
  output logic [MANT_W:0]   t_o,
  output logic [MANT_W-1:0] x_o
);

  localparam int PW = 2 * MANT_W + 1;
  localparam logic [MANT_W:0] TWO = (MANT_W + 1)'(TWO_Q(MANT_W));

  logic [MANT_W:0] b;
  logic [PW-1:0]   prod;
  logic [MANT_W:0] e;
  logic            ovf;
  logic            unused_lsb;

  assign b    = sel_x_i ? t_i : {1'b0, d_i};
  assign prod = PW'(x_i) * PW'(b);

  // truncate x*D to Q2.(MANT_W-1) and form 2 - x*D
  assign e   = prod[2*MANT_W-1:MANT_W-1];
  assign t_o = TWO - e;

  // anything at or above 2.0 in x*t pins x to all-ones
  assign ovf = |prod[PW-1:2*MANT_W-1];
  assign x_o = ovf ? '1 : prod[2*MANT_W-2:MANT_W-1];

  assign unused_lsb = ^prod[MANT_W-2:0];

endmodule

// File: rtl/recip_nr_iter.sv
// Iterative NR reciprocal refinement: FSM, counter and normalisation.
// Optional seed ROM selected by RECIP_SEED_LUT_EN.
module recip_nr_iter
  import recip_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int ITERS  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic [MANT_W-1:0]       in_x_mantissa,
  input  logic [MANT_W-1:0]       in_D_mantissa,
  input  logic [EXP_W-1:0]        in_exponent,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] recip
);

  localparam int RW = EXP_W + MANT_W;
  localparam logic [MANT_W-1:0] ONE = MANT_W'(ONE_Q(MANT_W));
  localparam logic [3:0] LAST = 4'(ITERS - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              sign_q;
  logic [MANT_W-1:0] x_q;
  logic [MANT_W-1:0] d_q;
  logic [MANT_W:0]   t_q;
  logic [EXP_W-1:0]  exp_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [RW-1:0]     recip_q;

  logic [MANT_W:0]   t_d;
  logic [MANT_W-1:0] x_d;
  logic [RW-1:0]     norm_d;
  logic [MANT_W-1:0] seed;
  logic              is_one;
  logic [EXP_W-1:0]  exp_dec;

`ifdef RECIP_SEED_LUT_EN
  logic [MANT_W+23:0] rom_ext;
  logic               unused_x;
  assign rom_ext  = {SEED_ROM[in_D_mantissa[MANT_W-2 -: 4]],
                     {MANT_W{1'b0}}};
  assign seed     = rom_ext[MANT_W+23 -: MANT_W];
  assign unused_x = ^in_x_mantissa;
`else
  assign seed = in_x_mantissa;
`endif

  recip_nr_datapath #(
    .MANT_W (MANT_W)
  ) u_dp (
    .sel_x_i (state_q == MUL_X),
    .x_i     (x_q),
    .d_i     (d_q),
    .t_i     (t_q),
    .t_o     (t_d),
    .x_o     (x_d)
  );

  assign is_one  = (x_q == ONE);
  assign exp_dec = exp_q - EXP_W'(1);

  // pack result; below-1.0 shifts up one place, tiny exponents flush
  always_comb begin
    norm_d = '0;
    if (exp_q == '0 || (!is_one && exp_q == EXP_W'(1)))
      norm_d = {sign_q, {(RW-1){1'b0}}};
    else if (is_one)
      norm_d = {sign_q, exp_q, {(MANT_W-1){1'b0}}};
    else
      norm_d = {sign_q, exp_dec, x_q[MANT_W-3:0], 1'b0};
  end

  // control FSM with registered handshake outputs and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      x_q         <= '0;
      d_q         <= '0;
      t_q         <= '0;
      exp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      recip_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sign_q     <= sign;
            x_q        <= seed;
            d_q        <= in_D_mantissa;
            exp_q      <= in_exponent;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL_D;
          end
        end
        MUL_D: begin
          t_q     <= t_d;
          state_q <= MUL_X;
        end
        MUL_X: begin
          x_q     <= x_d;
          cnt_q   <= cnt_q + 4'd1;
          state_q <= (cnt_q == LAST) ? NORM : MUL_D;
        end
        NORM: begin
          recip_q     <= norm_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign recip     = recip_q;

endmodule

// File: tb/tb_recip_nr_iter.sv
// Directed bench for recip_nr_iter (ITERS=2 main, ITERS=4/1 side units).
// Expected values are hand-traced fixed-point NR iterates.
module tb_recip_nr_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld, rdy, sgn, ovld, ordy;
  logic [23:0] xin, din;
  logic [7:0]  ein;
  logic [31:0] rec;
  logic        v4, rdy4, ovld4;
  logic [31:0] rec4;
  logic        v1, rdy1, ovld1;
  logic [31:0] rec1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  recip_nr_iter #(.MANT_W(24), .EXP_W(8), .ITERS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_ready(rdy),
    .sign(sgn), .in_x_mantissa(xin), .in_D_mantissa(din),
    .in_exponent(ein), .out_valid(ovld), .out_ready(ordy),
    .recip(rec)
  );

  recip_nr_iter #(.MANT_W(24), .EXP_W(8), .ITERS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
    .sign(sgn), .in_x_mantissa(xin), .in_D_mantissa(din),
    .in_exponent(ein), .out_valid(ovld4), .out_ready(ordy),
    .recip(rec4)
  );

  recip_nr_iter #(.MANT_W(24), .EXP_W(8), .ITERS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .sign(sgn), .in_x_mantissa(xin), .in_D_mantissa(din),
    .in_exponent(ein), .out_valid(ovld1), .out_ready(ordy),
    .recip(rec1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, rdy}, 32'd1);
  endtask

  task automatic run_op(input logic s, input logic [23:0] x,
                        input logic [23:0] d, input logic [7:0] e,
                        output logic [31:0] r, output int lat);
    @(negedge clk);
    wait_idle();
    sgn = s; xin = x; din = d; ein = e; vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    sgn = ~s; xin = 24'hABCDEF; din = 24'h123456; ein = 8'h55;
    lat = 1;
    while (!ovld && lat < 100) begin
      @(posedge clk);
      #1;
      if (!ovld) lat++;
    end
    check("out_valid", {31'd0, ovld}, 32'd1);
    r = rec;
  endtask

  logic [31:0] r, r2, r1, r4, hold_r;
  int lat, l2, l1, l4, n;
  logic g2, g1, g4;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; v4 = 1'b0; v1 = 1'b0; ordy = 1'b1;
    sgn = 1'b0; xin = '0; din = '0; ein = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, rdy}, 32'd1);
    check("rst_out_valid", {31'd0, ovld}, 32'd0);
    check("rst_recip", rec, 32'h0);
    rst_n = 1'b1;

    run_op(1'b0, 24'h800000, 24'h800000, 8'h7F, r, lat);
    check("one_val", r, 32'h3F800000);
    check("one_lat", 32'(lat), 32'd5);

    run_op(1'b0, 24'h555555, 24'hC00000, 8'h7F, r, lat);
    check("d15_val", r, 32'h3F2AAAAA);
    check("d15_lat", 32'(lat), 32'd5);

    run_op(1'b1, 24'h555555, 24'hC00000, 8'h7F, r, lat);
    check("d15_neg", r, 32'hBF2AAAAA);

    run_op(1'b0, 24'h500000, 24'hC00000, 8'h90, r, lat);
    check("d15_x50", r, 32'h47AAAA00);

    run_op(1'b1, 24'h555555, 24'hC00000, 8'h00, r, lat);
    check("flush_e0", r, 32'h80000000);
    run_op(1'b0, 24'h555555, 24'hC00000, 8'h01, r, lat);
    check("flush_e1", r, 32'h00000000);
    run_op(1'b0, 24'h800000, 24'h800000, 8'h01, r, lat);
    check("one_e1", r, 32'h00800000);

    // poor seed on all three units at once
    @(negedge clk);
    wait_idle();
    sgn = 1'b0; xin = 24'h400001; din = 24'hC00000; ein = 8'h7F;
    vld = 1'b1; v4 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0; v4 = 1'b0; v1 = 1'b0;
    g2 = 0; g1 = 0; g4 = 0; n = 0;
    r2 = '0; r1 = '0; r4 = '0; l2 = 0; l1 = 0; l4 = 0;
    while (!(g2 && g1 && g4) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ovld && !g2) begin g2 = 1; r2 = rec; l2 = n; end
      if (ovld1 && !g1) begin g1 = 1; r1 = rec1; l1 = n; end
      if (ovld4 && !g4) begin g4 = 1; r4 = rec4; l4 = n; end
    end
    check("poor_it2", r2, 32'h3F2A0000);
    check("poor_it1", r1, 32'h3F200000);
    check("poor_it4", r4, 32'h3F2AAAAA);
    check("lat_it2", 32'(l2), 32'd5);
    check("lat_it1", 32'(l1), 32'd3);
    check("lat_it4", 32'(l4), 32'd9);
    check("it1_err_big",
          {31'd0, (23'h2AAAAB - r1[22:0]) > 23'h080000}, 32'd1);

    // stall in DONE with out_ready low
    ordy = 1'b0;
    run_op(1'b1, 24'h800000, 24'h800000, 8'h40, r, lat);
    check("stall_val", r, 32'hA0000000);
    hold_r = r;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vld = 1'b1; xin = 24'h600000; din = 24'hA00000;
      ein = 8'h22; sgn = 1'b0;
      @(posedge clk);
      #1;
      check("hold_recip", rec, hold_r);
      check("hold_ready", {31'd0, rdy}, 32'd0);
      check("hold_valid", {31'd0, ovld}, 32'd1);
    end
    @(negedge clk);
    vld = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    check("rel_valid", {31'd0, ovld}, 32'd0);
    check("rel_ready", {31'd0, rdy}, 32'd1);
    run_op(1'b0, 24'h555555, 24'hC00000, 8'h7F, r, lat);
    check("after_hold", r, 32'h3F2AAAAA);

    // async reset in MUL_X of the first iteration
    @(negedge clk);
    wait_idle();
    sgn = 1'b0; xin = 24'h555555; din = 24'hC00000; ein = 8'h7F;
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_ready", {31'd0, rdy}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ovld}, 32'd0);
    check("arst_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 24'h800000, 24'h800000, 8'h7F, r, lat);
    check("post_rst_val", r, 32'h3F800000);
    check("post_rst_lat", 32'(lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
